// File: rtl/eim_rx_fifo_bridge.sv
// Receive-sample FIFO bridged onto the EIM bus: 32-bit samples in, 16-bit CSR
// and streaming data windows out. Block-RAM storage with first-word-fall-through.
module eim_rx_fifo_bridge #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [15:0] ID_VALUE   = 16'h5246
) (
  input  logic        bus_clk,
  input  logic        reset,
  input  logic [18:0] bus_addr,
  input  logic        bus_sel,
  input  logic        bus_wr,
  input  logic [15:0] bus_data_wr,
  output logic [15:0] bus_data_rd,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
);

  localparam int PW = DEPTH_LOG2 + 1;

  localparam logic [2:0] REGION_CSR  = 3'b000;
  localparam logic [2:0] REGION_DATA = 3'b001;

  typedef enum logic [2:0] {
    CSR_ID     = 3'd0,
    CSR_CTRL   = 3'd1,
    CSR_STATUS = 3'd2,
    CSR_LEVEL  = 3'd3,
    CSR_DROPS  = 3'd4
  } csr_e;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  enable_q, enable_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [15:0]           drops_q, drops_d;
  logic [15:0]           rd_data_q, rd_data_d;
  logic [31:0]           ram_q;
  logic                  byp_q;
  logic [31:0]           byp_data_q;
  logic [31:0]           mem [2**DEPTH_LOG2];

  logic [PW-1:0]         level;
  logic [15:0]           level_sat;
  logic                  empty, full;
  logic [31:0]           head;
  logic                  bus_rd, bus_we, csr_hit, data_hit;
  csr_e                  csr_idx;
  logic                  flush, push, drop, pop, underflow_set;
  logic                  ovf_clr, udf_clr, drops_clr;
  logic [DEPTH_LOG2-1:0] wr_addr, rd_addr;
  logic [15:0]           status_word;
  logic                  unused_addr;

  assign unused_addr = ^{bus_addr[15:4], bus_addr[0]};

  assign level = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  // A push landing on the address being fetched this edge is not yet visible
  // through the RAM read port, so it is presented from the bypass register.
  assign head  = byp_q ? byp_data_q : ram_q;

  assign in_ready    = enable_q && !full;
  assign bus_data_rd = rd_data_q;

  assign bus_rd   = bus_sel && !bus_wr;
  assign bus_we   = bus_sel && bus_wr;
  assign csr_hit  = (bus_addr[18:16] == REGION_CSR);
  assign data_hit = (bus_addr[18:16] == REGION_DATA);
  assign csr_idx  = csr_e'(bus_addr[3:1]);

  assign flush         = bus_we && csr_hit && (csr_idx == CSR_CTRL) && bus_data_wr[1];
  assign ovf_clr       = bus_we && csr_hit && (csr_idx == CSR_STATUS) && bus_data_wr[2];
  assign udf_clr       = bus_we && csr_hit && (csr_idx == CSR_STATUS) && bus_data_wr[3];
  assign drops_clr     = bus_we && csr_hit && (csr_idx == CSR_DROPS);
  assign push          = in_valid && in_ready && !flush;
  assign drop          = in_valid && enable_q && full && !flush;
  assign pop           = bus_rd && data_hit && !empty && bus_addr[1];
  assign underflow_set = bus_rd && data_hit && empty;

  assign status_word = {12'd0, underflow_q, overflow_q, full, empty};

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + PW'(pop);
  assign wr_addr  = wr_ptr_q[DEPTH_LOG2-1:0];
  assign rd_addr  = rd_ptr_d[DEPTH_LOG2-1:0];

  always_comb begin
    if (32'(level) > 32'h0000_FFFF) level_sat = 16'hFFFF;
    else                            level_sat = 16'(level);
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    rd_data_d   = rd_data_q;
    enable_d    = enable_q;
    overflow_d  = (overflow_q && !ovf_clr) || drop;
    underflow_d = (underflow_q && !udf_clr) || underflow_set;
    drops_d     = drops_clr ? 16'd0 : drops_q;
    if (drop && drops_d != 16'hFFFF) drops_d = drops_d + 16'd1;

    if (bus_we && csr_hit && csr_idx == CSR_CTRL) enable_d = bus_data_wr[0];

    if (bus_rd) begin
      if (csr_hit) begin
        case (csr_idx)
          CSR_ID:     rd_data_d = ID_VALUE;
          CSR_CTRL:   rd_data_d = {15'd0, enable_q};
          CSR_STATUS: rd_data_d = status_word;
          CSR_LEVEL:  rd_data_d = level_sat;
          CSR_DROPS:  rd_data_d = drops_q;
          default:    rd_data_d = 16'd0;
        endcase
      end else if (data_hit) begin
        if (empty)            rd_data_d = 16'd0;
        else if (bus_addr[1]) rd_data_d = head[31:16];
        else                  rd_data_d = head[15:0];
      end else begin
        rd_data_d = 16'd0;
      end
    end
  end

  // NOTE: the sample RAM and its read register carry no reset so they map onto
  // block RAM; FIFO validity is defined by the pointers alone.
  always_ff @(posedge bus_clk) begin
    if (push) mem[wr_addr] <= in_data;
    ram_q <= mem[rd_addr];
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values computed above.
  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      enable_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      drops_q     <= 16'd0;
      rd_data_q   <= 16'd0;
      byp_q       <= 1'b0;
      byp_data_q  <= 32'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      enable_q    <= enable_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      drops_q     <= drops_d;
      rd_data_q   <= rd_data_d;
      byp_q       <= push && (wr_addr == rd_addr);
      byp_data_q  <= in_data;
    end
  end

endmodule
